// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 shared widths, opcodes and T-state sequencing
package sap1_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } t_state_e;

  function automatic t_state_e next_t(input t_state_e t);
    t_state_e n;
    n = T1;
    case (t)
      T1:      n = T2;
      T2:      n = T3;
      T3:      n = T4;
      T4:      n = T5;
      T5:      n = T6;
      default: n = T1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// rtl/sap1_ram16x8.sv - 16x8 program/data RAM, synchronous write, asynchronous read
module sap1_ram16x8
  import sap1_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tt_um_sap_1.sv
// rtl/tt_um_sap_1.sv - SAP-1 computer: single-bus datapath with a six-state T-cycle controller
module tt_um_sap_1
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_halted;
  t_state_e          r_t;

  logic              w_load;
  logic              w_run;
  logic              w_we;
  logic              w_mem_op;
  logic [3:0]        w_opcode;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_bus;
  logic              w_unused;

  assign w_load   = ui_in[7];
  assign w_run    = ena & ~w_load & ~r_halted;
  assign w_we     = ena & w_load & ui_in[4] & ~rst_n;
  assign w_opcode = r_ir[7:4];
  assign w_mem_op = (w_opcode == OP_LDA) | (w_opcode == OP_ADD) | (w_opcode == OP_SUB);
  assign w_alu    = (w_opcode == OP_SUB) ? (r_a - r_b) : (r_a + r_b);
  assign w_unused = &{1'b0, ui_in[6:5]};

  sap1_ram16x8 u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (ui_in[3:0]),
    .i_wdata (uio_in),
    .i_raddr (r_mar),
    .o_rdata (w_ram_rdata)
  );

  // Exactly one source per T-state; load mode and halt float the bus to zero.
  always_comb begin
    w_bus = '0;
    if (!w_load && !r_halted) begin
      case (r_t)
        T1: w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
        T3: w_bus = w_ram_rdata;
        T4: begin
          if (w_mem_op)                 w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[3:0]};
          else if (w_opcode == OP_OUT)  w_bus = r_a;
        end
        T5: if (w_mem_op) w_bus = w_ram_rdata;
        T6: if ((w_opcode == OP_ADD) || (w_opcode == OP_SUB)) w_bus = w_alu;
        default: w_bus = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pc     <= '0;
      r_mar    <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_out    <= '0;
      r_halted <= 1'b0;
      r_t      <= T1;
    end else if (w_run) begin
      r_t <= next_t(r_t);
      case (r_t)
        T1: r_mar <= w_bus[ADDR_W-1:0];
        T2: r_pc  <= r_pc + 4'd1;
        T3: r_ir  <= w_bus;
        T4: begin
          if (w_mem_op)                r_mar    <= w_bus[ADDR_W-1:0];
          else if (w_opcode == OP_OUT) r_out    <= w_bus;
          else if (w_opcode == OP_HLT) r_halted <= 1'b1;
        end
        T5: begin
          if (w_opcode == OP_LDA)                                  r_a <= w_bus;
          else if ((w_opcode == OP_ADD) || (w_opcode == OP_SUB))   r_b <= w_bus;
        end
        T6: if ((w_opcode == OP_ADD) || (w_opcode == OP_SUB)) r_a <= w_bus;
        default: ;
      endcase
    end
  end

  assign uo_out  = w_bus;
  assign uio_out = r_out;
  assign uio_oe  = w_load ? 8'h00 : 8'hFF;

endmodule

// File: tb/tb_tt_um_sap_1.sv
// tb/tb_tt_um_sap_1.sv - self-checking bench for the SAP-1 computer against an instruction-level model
module tb_tt_um_sap_1;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  logic [7:0] prog [16];
  logic [7:0] bus_q [$];
  logic [7:0] out_q [$];
  logic [7:0] model_out;

  tt_um_sap_1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: each instruction contributes six bus values
  // (one per T-state) and the OUT register value after each edge.
  task automatic build_model();
    logic [3:0] pc, opr;
    logic [7:0] a, b, o, ir;
    bit done;
    bus_q.delete();
    out_q.delete();
    pc = 0; a = 0; b = 0; o = 0; done = 0;
    for (int g = 0; g < 32 && !done; g++) begin
      ir  = prog[pc];
      opr = ir[3:0];
      bus_q.push_back({4'h0, pc}); out_q.push_back(o);
      bus_q.push_back(8'h00);      out_q.push_back(o);
      bus_q.push_back(ir);         out_q.push_back(o);
      pc = pc + 4'd1;
      case (ir[7:4])
        4'h0, 4'h1, 4'h2: begin
          bus_q.push_back({4'h0, opr}); out_q.push_back(o);
          bus_q.push_back(prog[opr]);   out_q.push_back(o);
          if (ir[7:4] == 4'h0) begin
            a = prog[opr];
            bus_q.push_back(8'h00);
          end else begin
            b = prog[opr];
            a = (ir[7:4] == 4'h1) ? 8'((int'(a) + int'(b)) % 256)
                                  : 8'((int'(a) - int'(b) + 256) % 256);
            bus_q.push_back(a);
          end
          out_q.push_back(o);
        end
        4'hE: begin
          bus_q.push_back(a); o = a; out_q.push_back(o);
          bus_q.push_back(8'h00); out_q.push_back(o);
          bus_q.push_back(8'h00); out_q.push_back(o);
        end
        4'hF: begin
          bus_q.push_back(8'h00); out_q.push_back(o);
          done = 1;
        end
        default: begin
          repeat (3) begin
            bus_q.push_back(8'h00); out_q.push_back(o);
          end
        end
      endcase
    end
    model_out = o;
  endtask

  task automatic load_prog();
    ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ui_in  = {1'b1, 2'b00, 1'b1, 4'(i)};
      uio_in = prog[i];
      step();
    end
    ui_in = 8'h80;
  endtask

  task automatic load_spec_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h2B; prog[3] = 8'hE0; prog[4] = 8'hF0;
    prog[9] = 8'h10; prog[10] = 8'h14; prog[11] = 8'h18;
    load_prog();
  endtask

  // Runs the current program to halt, comparing every T-state bus value and
  // OUT after every edge, optionally freezing with ena=0 for 5 edges at pause_at.
  task automatic run_trace(input string name, input bit do_rst, input int pause_at);
    logic [7:0] prev_out;
    build_model();
    ui_in = 8'h00;
    ena   = 1'b1;
    if (do_rst) begin
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
    end
    for (int k = 0; k < bus_q.size(); k++) begin
      prev_out = (k == 0) ? 8'h00 : out_q[k-1];
      n_checks++;
      if (uo_out !== bus_q[k]) begin
        n_fail++;
        $display("FAIL %s bus step %0d: got %02h expected %02h", name, k, uo_out, bus_q[k]);
      end
      if (k == pause_at) begin
        ena = 1'b0;
        repeat (5) step();
        n_checks++;
        if (uo_out !== bus_q[k] || uio_out !== prev_out) begin
          n_fail++;
          $display("FAIL %s ena_freeze step %0d: bus %02h out %02h expected bus %02h out %02h",
                   name, k, uo_out, uio_out, bus_q[k], prev_out);
        end
        ena = 1'b1;
      end
      step();
      n_checks++;
      if (uio_out !== out_q[k]) begin
        n_fail++;
        $display("FAIL %s out after edge %0d: got %02h expected %02h", name, k + 1, uio_out, out_q[k]);
      end
    end
    for (int e = 0; e < 20; e++) begin
      step();
      n_checks++;
      if (uo_out !== 8'h00 || uio_out !== model_out) begin
        n_fail++;
        $display("FAIL %s halted edge %0d: bus %02h out %02h expected bus 00 out %02h",
                 name, e, uo_out, uio_out, model_out);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    step(); step();
    n_checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_state: bus %02h out %02h oe %02h expected 00 00 ff", uo_out, uio_out, uio_oe);
    end
    rst_n = 1'b0;
    ui_in = 8'h80;
    #1;
    n_checks++;
    if (uio_oe !== 8'h00 || uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL load_mode_outputs: oe %02h bus %02h expected 00 00", uio_oe, uo_out);
    end
    ui_in = 8'h00;
  endtask

  task automatic test_program();
    logic [7:0] first [6];
    first[0] = 8'h00; first[1] = 8'h00; first[2] = 8'h09;
    first[3] = 8'h09; first[4] = 8'h10; first[5] = 8'h00;
    load_spec_prog();
    ui_in = 8'h00;
    rst_n = 1'b1; step(); rst_n = 1'b0;
    for (int t = 0; t < 6; t++) begin
      n_checks++;
      if (uo_out !== first[t]) begin
        n_fail++;
        $display("FAIL first_instr_bus T%0d: got %02h expected %02h", t + 1, uo_out, first[t]);
      end
      step();
    end
    repeat (15) step();
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL out_before_edge22: got %02h expected 00", uio_out);
    end
    step();
    n_checks++;
    if (uio_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL out_at_edge22: got %02h expected 0c", uio_out);
    end
    run_trace("spec_prog", 1'b1, -1);
    n_checks++;
    if (uio_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL spec_prog_final: got %02h expected 0c", uio_out);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h05; prog[1] = 8'h16; prog[2] = 8'hE0; prog[3] = 8'hF0;
    prog[5] = 8'hF0; prog[6] = 8'h20;
    load_prog();
    run_trace("wrap_add", 1'b1, -1);
    n_checks++;
    if (uio_out !== 8'h10) begin
      n_fail++;
      $display("FAIL wrap_add_final: got %02h expected 10", uio_out);
    end
    prog[1] = 8'h26; prog[6] = 8'hF1;
    load_prog();
    run_trace("wrap_sub", 1'b1, -1);
    n_checks++;
    if (uio_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_sub_final: got %02h expected ff", uio_out);
    end
  endtask

  task automatic test_strobe_low();
    load_spec_prog();
    ui_in  = {1'b1, 2'b00, 1'b0, 4'h9};
    uio_in = 8'h77;
    repeat (3) step();
    ui_in  = {1'b0, 2'b00, 1'b1, 4'hA};
    uio_in = 8'h55;
    step();
    run_trace("strobe_low", 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    load_spec_prog();
    ui_in = 8'h00;
    rst_n = 1'b1; step(); rst_n = 1'b0;
    repeat (8) step();
    n_checks++;
    if (uo_out !== 8'h1A) begin
      n_fail++;
      $display("FAIL reset_mid_pre T3: got %02h expected 1a", uo_out);
    end
    rst_n = 1'b1; step(); rst_n = 1'b0;
    n_checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_post: bus %02h out %02h expected 00 00", uo_out, uio_out);
    end
    run_trace("reset_mid", 1'b0, -1);
  endtask

  task automatic test_ena_pause();
    load_spec_prog();
    run_trace("ena_pause", 1'b1, 13);
  endtask

  task automatic test_random();
    int n;
    logic [3:0] op;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 4))
          0:       op = 4'h0;
          1:       op = 4'h1;
          2:       op = 4'h2;
          3:       op = 4'hE;
          default: op = 4'($urandom_range(3, 13));
        endcase
        prog[i] = {op, 4'($urandom)};
      end
      prog[n]   = 8'hE0;
      prog[n+1] = 8'hF0;
      load_prog();
      run_trace($sformatf("random_%0d", r), 1'b1, (r % 3 == 0) ? int'($urandom_range(0, 6 * n)) : -1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    test_reset();
    test_program();
    test_wrap();
    test_strobe_low();
    test_reset_mid();
    test_ena_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
